div_unit: RTL

- Multi-cycle 32-bit radix-2 restoring divider used by the EX stage for DIV and DIVU.
- It is the requester side of the pipeline-control stall/flush handshake.
- It raises `stallreq_o`, which EX forwards to the controller as its execute-stage stall request, and it obeys the controller's flush via `annul_i`.
- Result is {remainder, quotient}, written to HI/LO.

---
 rtl/div_unit_if.sv | 24 ++
 rtl/div_unit.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/div_unit_if.sv
// Handshake bundle between the EX stage and the multi-cycle divider.
// Signal names match the original flat port list for drop-in compatibility.
interface div_unit_if #(
  parameter int unsigned DATA_W = 32
);
  logic                  start_i;
  logic                  signed_div_i;
  logic [DATA_W-1:0]     opdata1_i;
  logic [DATA_W-1:0]     opdata2_i;
  logic                  annul_i;
  logic [2*DATA_W-1:0]   result_o;
  logic                  ready_o;
  logic                  stallreq_o;

  modport master (
    output start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  start_i, signed_div_i, opdata1_i, opdata2_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU; result = {remainder, quotient}.
// Optional DIV_EARLY_OUT_EN: finish at accept when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 6
) (
  input logic       clk,
  input logic       rst,
  div_unit_if.slave bus
);

  localparam int unsigned DW = DATA_W;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [2*DW:0]     r_dividend, w_dividend_nxt;
  logic [DW-1:0]     r_divisor, w_divisor_nxt;
  logic              r_signed, w_signed_nxt;
  logic              r_neg_q, w_neg_q_nxt;
  logic              r_neg_r, w_neg_r_nxt;
  logic [2*DW-1:0]   r_result, w_result_nxt;
  logic              r_ready, w_ready_nxt;

  logic [DW-1:0]     w_op1_mag, w_op2_mag;
  logic [DW:0]       w_diff;
  logic [DW-1:0]     w_quot, w_rem;
  logic              w_early;

  always_comb begin
    w_op1_mag = bus.opdata1_i;
    w_op2_mag = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[DW-1]) w_op1_mag = -bus.opdata1_i;
    if (bus.signed_div_i && bus.opdata2_i[DW-1]) w_op2_mag = -bus.opdata2_i;
  end

`ifdef DIV_EARLY_OUT_EN
  assign w_early = (w_op1_mag < w_op2_mag);
`else
  assign w_early = 1'b0;
`endif

  // Trial subtraction against the upper half of the shifted dividend.
  assign w_diff = {1'b0, r_dividend[2*DW-1:DW]} - {1'b0, r_divisor};

  always_comb begin
    w_quot = r_dividend[DW-1:0];
    w_rem  = r_dividend[2*DW:DW+1];
    if (r_neg_q) w_quot = -r_dividend[DW-1:0];
    if (r_neg_r) w_rem  = -r_dividend[2*DW:DW+1];
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_dividend_nxt = r_dividend;
    w_divisor_nxt  = r_divisor;
    w_signed_nxt   = r_signed;
    w_neg_q_nxt    = r_neg_q;
    w_neg_r_nxt    = r_neg_r;
    w_result_nxt   = r_result;
    w_ready_nxt    = r_ready;

    if (bus.annul_i) begin
      w_state_nxt  = FREE;
      w_cnt_nxt    = '0;
      w_result_nxt = '0;
      w_ready_nxt  = 1'b0;
    end else begin
      unique case (r_state)
        FREE: begin
          w_result_nxt = '0;
          w_ready_nxt  = 1'b0;
          if (bus.start_i) begin
            w_signed_nxt = bus.signed_div_i;
            w_neg_q_nxt  = bus.signed_div_i & (bus.opdata1_i[DW-1] ^ bus.opdata2_i[DW-1]);
            w_neg_r_nxt  = bus.signed_div_i & bus.opdata1_i[DW-1];
            if (bus.opdata2_i == '0) begin
              w_state_nxt = BYZERO;
            end else if (w_early) begin
              w_state_nxt  = END;
              w_result_nxt = {bus.opdata1_i, {DW{1'b0}}};
              w_ready_nxt  = 1'b1;
            end else begin
              w_state_nxt    = ON;
              w_cnt_nxt      = '0;
              w_dividend_nxt = {{DW{1'b0}}, w_op1_mag, 1'b0};
              w_divisor_nxt  = w_op2_mag;
            end
          end
        end
        BYZERO: begin
          w_state_nxt  = END;
          w_result_nxt = '0;
          w_ready_nxt  = 1'b1;
        end
        ON: begin
          if (r_cnt != LAST) begin
            if (w_diff[DW]) w_dividend_nxt = {r_dividend[2*DW-1:0], 1'b0};
            else            w_dividend_nxt = {w_diff[DW-1:0], r_dividend[DW-1:0], 1'b1};
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end else begin
            w_state_nxt  = END;
            w_result_nxt = {w_rem, w_quot};
            w_ready_nxt  = 1'b1;
          end
        end
        END: begin
          if (!bus.start_i) begin
            w_state_nxt  = FREE;
            w_result_nxt = '0;
            w_ready_nxt  = 1'b0;
          end
        end
        default: w_state_nxt = FREE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= FREE;
      r_cnt      <= '0;
      r_dividend <= '0;
      r_divisor  <= '0;
      r_signed   <= 1'b0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_result   <= '0;
      r_ready    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dividend <= w_dividend_nxt;
      r_divisor  <= w_divisor_nxt;
      r_signed   <= w_signed_nxt;
      r_neg_q    <= w_neg_q_nxt;
      r_neg_r    <= w_neg_r_nxt;
      r_result   <= w_result_nxt;
      r_ready    <= w_ready_nxt;
    end
  end

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.stallreq_o = bus.start_i & ~r_ready & ~bus.annul_i;

endmodule
